// File: rtl/instruction_fetch_queue.sv
// Sequential prefetch buffer: presents fetchPC to the ICache every cycle and queues
// each hit word with its address; ROB clear and decode jump flush and reload the PC.
module instruction_fetch_queue #(
  parameter int unsigned QUEUE_WIDTH = 3,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        readyIn,
  input  logic        clearIn,
  input  logic [31:0] redirectPC,
  input  logic        jumpIn,
  input  logic [31:0] jumpPC,
  output logic [31:0] fetchAddr,
  input  logic        icacheHit,
  input  logic [31:0] icacheData,
  output logic        outValid,
  output logic [31:0] outIns,
  output logic [31:0] outAddr,
  input  logic        popIn,
  output logic        full
);

  localparam int unsigned DEPTH = 1 << QUEUE_WIDTH;
  localparam logic [QUEUE_WIDTH:0] DEPTH_CNT = {1'b1, {QUEUE_WIDTH{1'b0}}};

  logic [31:0]            fetch_pc;
  logic [QUEUE_WIDTH-1:0] head;
  logic [QUEUE_WIDTH-1:0] tail;
  logic [QUEUE_WIDTH:0]   count;
  logic [31:0]            addr_mem [DEPTH];
  logic [31:0]            ins_mem  [DEPTH];

  logic push;
  logic pop;
  logic write_en;

  // Push uses the pre-edge count, so a full queue never accepts a word even while popping.
  always_comb begin
    push     = icacheHit && (count < DEPTH_CNT);
    pop      = popIn && outValid;
    write_en = !resetIn && readyIn && !clearIn && !jumpIn && push;
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (readyIn) begin
      if (clearIn) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        fetch_pc <= redirectPC & 32'hFFFF_FFFC;
      end else if (jumpIn) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        fetch_pc <= jumpPC & 32'hFFFF_FFFC;
      end else begin
        if (push) begin
          tail     <= tail + 1'b1;
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (pop) head <= head + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clockIn) begin
    if (write_en) begin
      addr_mem[tail] <= fetch_pc;
      ins_mem[tail]  <= icacheData;
    end
  end

  always_comb begin
    fetchAddr = fetch_pc;
    outValid  = (count != '0);
    full      = (count == DEPTH_CNT);
    outIns    = outValid ? ins_mem[head]  : '0;
    outAddr   = outValid ? addr_mem[head] : '0;
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Scoreboard bench for instruction_fetch_queue: stimulus queues expected entries,
// a negedge monitor checks every accepted pop against the scoreboard front.
module tb_instruction_fetch_queue;

  logic        clk = 1'b0;
  logic        resetIn = 1'b0;
  logic        readyIn = 1'b0;
  logic        clearIn = 1'b0;
  logic [31:0] redirectPC = '0;
  logic        jumpIn = 1'b0;
  logic [31:0] jumpPC = '0;
  logic [31:0] fetchAddr;
  logic        icacheHit = 1'b0;
  logic [31:0] icacheData = '0;
  logic        outValid;
  logic [31:0] outIns;
  logic [31:0] outAddr;
  logic        popIn = 1'b0;
  logic        full;

  int checks = 0;
  int failures = 0;

  logic [63:0] sb [$];
  logic [31:0] exp_pc = 32'h0;

  instruction_fetch_queue #(.QUEUE_WIDTH(3), .RESET_PC(32'h0)) dut (
    .clockIn(clk), .resetIn(resetIn), .readyIn(readyIn), .clearIn(clearIn),
    .redirectPC(redirectPC), .jumpIn(jumpIn), .jumpPC(jumpPC), .fetchAddr(fetchAddr),
    .icacheHit(icacheHit), .icacheData(icacheData), .outValid(outValid),
    .outIns(outIns), .outAddr(outAddr), .popIn(popIn), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every pop the DUT will accept this cycle must match the scoreboard front.
  always @(negedge clk) begin
    if (!resetIn && readyIn && popIn && outValid && !clearIn && !jumpIn) begin
      logic [63:0] e;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected actual_addr=%h expected=empty", outAddr);
      end else begin
        e = sb.pop_front();
        chk("pop_addr", outAddr, e[63:32]);
        chk("pop_ins", outIns, e[31:0]);
      end
    end
  end

  task automatic post_check();
    chk("fetchAddr", fetchAddr, exp_pc);
    chk("outValid", {31'b0, outValid}, {31'b0, sb.size() != 0});
    chk("full", {31'b0, full}, {31'b0, sb.size() == 8});
    if (sb.size() == 0) begin
      chk("empty_addr", outAddr, 32'h0);
      chk("empty_ins", outIns, 32'h0);
    end
  endtask

  // One clock: drive inputs, predict the edge, then compare after it.
  task automatic cyc(input bit rdy, input bit hit, input bit pop, input bit clr,
                     input logic [31:0] rpc, input bit jmp, input logic [31:0] jpc);
    int unsigned pre_cnt;
    bit          do_push;
    logic [31:0] data;
    data       = exp_pc ^ 32'hA5A5_0000;
    readyIn    = rdy;
    icacheHit  = hit;
    icacheData = data;
    popIn      = pop;
    clearIn    = clr;
    redirectPC = rpc;
    jumpIn     = jmp;
    jumpPC     = jpc;
    pre_cnt    = sb.size();
    do_push    = rdy && !clr && !jmp && hit && (pre_cnt < 8);
    @(posedge clk);
    #1;
    if (rdy) begin
      if (clr) begin
        sb.delete();
        exp_pc = {rpc[31:2], 2'b00};
      end else if (jmp) begin
        sb.delete();
        exp_pc = {jpc[31:2], 2'b00};
      end else if (do_push) begin
        sb.push_back({exp_pc, data});
        exp_pc = exp_pc + 32'd4;
      end
    end
    post_check();
  endtask

  task automatic do_reset();
    resetIn = 1'b1;
    readyIn = 1'b0;
    popIn = 1'b1;
    icacheHit = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetIn = 1'b0;
    sb.delete();
    exp_pc = 32'h0;
    post_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Stream 8 hits into an empty queue, then a 9th that must not push.
    repeat (8) cyc(1, 1, 0, 0, 0, 0, 0);
    chk("full_after_8", {31'b0, full}, 32'd1);
    chk("pc_after_8", fetchAddr, 32'h20);
    chk("head_addr", outAddr, 32'h0);
    chk("head_ins", outIns, 32'hA5A5_0000);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("pc_9th_hit", fetchAddr, 32'h20);

    // Full with pop: no push this edge, then pop+hit keeps count at 7.
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("pc_full_pop", fetchAddr, 32'h20);
    chk("not_full_after_pop", {31'b0, full}, 32'd0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    chk("pc_after_refill", fetchAddr, 32'h24);
    chk("sb_depth_7", sb.size(), 32'd7);

    // Steady state across several pointer wraps.
    repeat (20) cyc(1, 1, 1, 0, 0, 0, 0);

    // Clear and jump together: clear wins, low PC bits dropped.
    cyc(1, 1, 1, 1, 32'h1003, 1, 32'h200);
    chk("clr_pc", fetchAddr, 32'h1000);
    chk("clr_valid", {31'b0, outValid}, 32'd0);

    // Jump flush with a same-cycle pop.
    repeat (5) cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 1, 32'h80);
    chk("jmp_pc", fetchAddr, 32'h80);
    chk("jmp_valid", {31'b0, outValid}, 32'd0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("jmp_head", outAddr, 32'h80);
    cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);

    // Freeze: pops and hits ignored, then a miss holds everything.
    repeat (3) cyc(0, 1, 1, 0, 0, 1, 32'h400);
    chk("freeze_pc", fetchAddr, 32'h8C);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("miss_pc", fetchAddr, 32'h8C);
    chk("miss_depth", sb.size(), 32'd1);
    cyc(1, 0, 1, 0, 0, 0, 0);

    // Reset mid-stream then a short refill.
    repeat (4) cyc(1, 1, 0, 0, 0, 0, 0);
    do_reset();
    chk("rst_pc", fetchAddr, 32'h0);
    repeat (3) cyc(1, 1, 0, 0, 0, 0, 0);
    repeat (3) cyc(1, 0, 1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Sequential prefetch buffer between the ICache and the InstructionUnit. Holds a fetch PC, presents it to the ICache every cycle, and pushes each hit word with its address into a circular queue. The InstructionUnit pops decoded instructions from the head. Two redirect sources flush the queue and reload the fetch PC:

- ROB mispredict clear.
- Decode-time jump from the InstructionUnit.

## Interface

Parameters:
- QUEUE_WIDTH, 3: log2 of queue depth (DEPTH = 2^QUEUE_WIDTH = 8).
- RESET_PC, 32'h0: fetch PC after reset.

Ports:
- clockIn  in  1  system clock; single clock domain.
- resetIn  in  1  synchronous, active-high reset.
- readyIn  in  1  freeze when low.
- clearIn  in  1  ROB flush request.
- redirectPC  in  32  target PC accompanying clearIn.
- jumpIn  in  1  decode redirect (JAL or predicted-taken branch).
- jumpPC  in  32  target PC accompanying jumpIn.
- fetchAddr  out  32  address presented to the ICache; equals fetchPC.
- icacheHit  in  1  ICache holds fetchAddr this cycle (combinational).
- icacheData  in  32  instruction word at fetchAddr when icacheHit.
- outValid  out  1  head entry is valid.
- outIns  out  32  head instruction word.
- outAddr  out  32  head instruction address.
- popIn  in  1  consumer takes the head entry this cycle.
- full  out  1  count == DEPTH.

## Operation

**State:**
- fetchPC[31:0]
- head and tail pointers, QUEUE_WIDTH bits each, wrapping modulo DEPTH.
- count, QUEUE_WIDTH+1 bits.
- DEPTH entries of {addr[31:0], ins[31:0]}.

**Reset** (resetIn high at a rising edge):
- fetchPC = RESET_PC; head = tail = count = 0.
- outValid = 0, outIns = 0, outAddr = 0, full = 0.
- Reset overrides readyIn.

**Freeze:** with readyIn low and resetIn low, all registers hold. popIn, clearIn and jumpIn are ignored.

**Per-edge priority** (readyIn high):
1. **clearIn high:**
   - head = tail = count = 0.
   - fetchPC = {redirectPC[31:2], 2'b00}.
   - No push or pop this edge; jumpIn is ignored.
2. **jumpIn high** (clearIn low):
   - Same flush as clearIn, with fetchPC = {jumpPC[31:2], 2'b00}.
   - popIn this cycle is ignored. The InstructionUnit has already consumed the jumping instruction through the same-cycle pop; the flush discards everything behind it.
3. **Otherwise**, push and pop are evaluated independently:
   - **push** = icacheHit && (count < DEPTH), where count is the pre-edge value.
     - Writes {fetchPC, icacheData} at tail; tail += 1; fetchPC += 4 (modulo 2^32).
   - **pop** = popIn && outValid.
     - head += 1.
   - **count update:** count += push − pop. Simultaneous push and pop leaves count unchanged.
   - **Full queue:** no push even if pop is asserted (full uses the pre-edge count). This is deliberate; there is no bypass.
   - **Miss** (icacheHit low): no push; fetchPC holds. The ICache fills on its own.

**Outputs** (combinational from registers):
- outValid = (count != 0).
- outIns / outAddr = entry[head] when outValid, else 0.
- full = (count == DEPTH).
- fetchAddr = fetchPC.

**Constraints:**
- popIn with outValid low is a no-op.
- Entries are written only on push; there is no other write path.

## Timing

- ICache hit to visible head: a word hit in cycle N is pushed at edge N. outValid rises in cycle N+1 if the queue was empty. No empty-queue bypass.
- Sustained throughput: one push and one pop per cycle when the ICache hits continuously.
- Redirect to first fetch: after the flush edge, fetchAddr = new PC in the next cycle. The first push can occur at the following edge on a hit. outValid is 0 for at least one cycle after any flush.
- Wrap-around: tail and head wrap from DEPTH−1 to 0 with no bubble.
- Reset mid-operation: all queued entries are discarded; behaviour is identical to power-on.

## Test plan

- **Reset then stream:** RESET_PC=0, icacheHit=1 with data = addr^32'hA5A5_0000, popIn=0.
  - After 8 edges: full=1, fetchAddr=0x20.
  - Head outAddr=0x0, outIns=0xA5A5_0000.
  - A 9th hit does not push.
- **Full with simultaneous pop:** full queue, popIn=1, icacheHit=1 for one edge.
  - count → 7, fetchAddr stays 0x20.
  - Next edge with pop+hit: count stays 7; the entry with addr 0x20 enters.
- **Steady state plus wrap:** hit and pop every cycle for 20 cycles.
  - Consumed outAddr sequence is contiguous (0x0, 0x4, ...), no gaps or duplicates across pointer wrap.
- **Clear vs jump same cycle:** clearIn=1, redirectPC=0x1003, jumpIn=1, jumpPC=0x200.
  - Result: count=0, outValid=0, fetchAddr=0x1000.
- **Jump flush with pop:** 5 entries queued, jumpIn=1, jumpPC=0x80, popIn=1.
  - Result: count=0, fetchAddr=0x80.
  - With hits on the following edges, the next heads are 0x80, 0x84.
- **Freeze and miss:** readyIn=0 for 3 cycles with popIn=1 and icacheHit=1: nothing changes. Then readyIn=1 with icacheHit=0: fetchAddr holds and count holds.
